// File: rtl/unit_test_sequencer.sv
// Runs up to NUM_TESTS unit-test slots one at a time through an enable/done handshake,
// with a per-test timeout, an inter-test reset gap, a skip mask and optional stop-on-fail.
module unit_test_sequencer #(
  parameter int unsigned NUM_TESTS    = 23,
  parameter int unsigned TIMEOUT_W    = 32,
  parameter int unsigned GAP_CYCLES   = 8,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_TESTS-1:0]         test_mask,
  input  logic [TIMEOUT_W-1:0]         timeout_cycles,
  input  logic [NUM_TESTS-1:0]         test_done,
  input  logic [NUM_TESTS-1:0]         test_error,
  output logic [NUM_TESTS-1:0]         test_en,
  output logic                         test_rst_n,
  output logic [$clog2(NUM_TESTS):0]   cur_test,
  output logic                         busy,
  output logic                         all_done,
  output logic                         pass,
  output logic [NUM_TESTS-1:0]         fail_vec,
  output logic [NUM_TESTS-1:0]         timeout_vec,
  output logic [NUM_TESTS-1:0]         ran_vec
);

  localparam int unsigned CW = $clog2(NUM_TESTS) + 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StSelect, StRun, StGap, StFinish} state_e;

  state_e                 state_q;
  logic [NUM_TESTS-1:0]   mask_q;
  logic [TIMEOUT_W-1:0]   tmo_q;
  logic [TIMEOUT_W-1:0]   cnt_q;
  logic [GW-1:0]          gap_q;
  logic [CW-1:0]          idx_q;
  logic                   last_fail_q;

  logic                   found;
  logic [CW-1:0]          sel;
  logic [NUM_TESTS-1:0]   sel_oh;
  logic                   done_cur;
  logic                   err_cur;
  logic                   tmo_hit;

  // Lowest enabled slot at or above idx_q; iterate downwards so the lowest match wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = int'(NUM_TESTS) - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(idx_q))) begin
        found = 1'b1;
        sel   = CW'(i);
      end
    end
    sel_oh = NUM_TESTS'(1) << sel;
  end

  // test_en is one-hot on the running slot, so masking avoids a variable index.
  assign done_cur = |(test_done & test_en);
  assign err_cur  = |(test_error & test_en);
  assign tmo_hit  = (tmo_q != '0) && (cnt_q == tmo_q - TIMEOUT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      tmo_q       <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      idx_q       <= '0;
      last_fail_q <= 1'b0;
      test_en     <= '0;
      test_rst_n  <= 1'b0;
      cur_test    <= '0;
      busy        <= 1'b0;
      all_done    <= 1'b0;
      pass        <= 1'b0;
      fail_vec    <= '0;
      timeout_vec <= '0;
      ran_vec     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mask_q      <= test_mask;
            tmo_q       <= timeout_cycles;
            fail_vec    <= '0;
            timeout_vec <= '0;
            ran_vec     <= '0;
            all_done    <= 1'b0;
            pass        <= 1'b0;
            busy        <= 1'b1;
            idx_q       <= '0;
            state_q     <= StSelect;
          end
        end
        StSelect: begin
          if (found) begin
            cur_test   <= sel;
            test_en    <= sel_oh;
            test_rst_n <= 1'b1;
            cnt_q      <= '0;
            state_q    <= StRun;
          end else begin
            // Completion flags are set on entry to FINISH so they are visible during it.
            busy     <= 1'b0;
            all_done <= 1'b1;
            pass     <= ~|fail_vec;
            state_q  <= StFinish;
          end
        end
        StRun: begin
          if (~&cnt_q) cnt_q <= cnt_q + TIMEOUT_W'(1);
          if (done_cur || tmo_hit) begin
            ran_vec     <= ran_vec | test_en;
            test_en     <= '0;
            test_rst_n  <= 1'b0;
            gap_q       <= '0;
            state_q     <= StGap;
            if (done_cur) begin
              fail_vec    <= fail_vec | (test_en & {NUM_TESTS{err_cur}});
              last_fail_q <= err_cur;
            end else begin
              fail_vec    <= fail_vec | test_en;
              timeout_vec <= timeout_vec | test_en;
              last_fail_q <= 1'b1;
            end
          end
        end
        StGap: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) begin
            idx_q <= cur_test + CW'(1);
            if (STOP_ON_FAIL && last_fail_q) begin
              busy     <= 1'b0;
              all_done <= 1'b1;
              pass     <= ~|fail_vec;
              state_q  <= StFinish;
            end else begin
              state_q <= StSelect;
            end
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule
